pwm_output_stage: RTL and testbench
===================================

Name: pwm_output_stage

Overview:
Downstream stage of pid_controller. It consumes the 8-bit control word, applies a per-period slew limit with soft start and soft stop, and drives a single-ended PWM pin. It also emits a period-start pulse and a mid-on-time sample strobe, so the feedback ADC can be sampled synchronously to the switching.

Parameters:
MAX_STEP, 8'd16, maximum change of the applied duty per PWM period (1..255)
PERIOD_MAX, 8'd254, last count value; period is PERIOD_MAX+1 = 255 ticks

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
duty_in  input  8  requested duty (pid_controller control_out)
duty_valid  input  1  one-clk strobe: capture duty_in into target
prescale  input  8  tick divider; a tick occurs every prescale+1 clks
enable  input  1  1 = run or ramp up, 0 = ramp down then idle
pwm_out  output  1  registered PWM output
duty_active  output  8  duty currently applied
period_start  output  1  one-clk pulse on the first clk of each period
sample_strobe  output  1  one-clk pulse at the centre of the on-time
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, target=0, duty_active=0, pre_cnt=0, cnt=0, prescale_lat=0, and all outputs 0.
- Prescaler:
  - pre_cnt counts 0..prescale_lat; tick=1 when pre_cnt==prescale_lat, then pre_cnt wraps to 0.
  - prescale_lat=0 gives a tick every clk.
  - prescale is latched into prescale_lat only at a period boundary and on IDLE->RUN. Mid-period changes take effect from the next period.
- Period counter: cnt advances 0..PERIOD_MAX on each tick. Boundary = tick && cnt==PERIOD_MAX; cnt then wraps to 0.
- Target capture: duty_valid=1 sets target<=duty_in. The last write before a boundary wins. A write in the same clk as a boundary is NOT used at that boundary; it takes effect at the next boundary.
- Slew at each boundary (target_eff = target in RUN, 0 in STOP):
  - if |target_eff-duty_active| <= MAX_STEP: duty_active <= target_eff
  - else: duty_active moves by MAX_STEP toward target_eff
  - The difference is computed in 9-bit signed arithmetic; the result never wraps below 0 or above 255.
- pwm_out:
  - pwm_out <= (state!=IDLE) && (cnt < duty_active), evaluated every clk (1-clk latency from cnt/duty_active).
  - duty 0 gives constant low; duty 255 gives constant high (cnt never reaches 255).
- period_start: 1 in the clk after a boundary, and in the clk after IDLE->RUN.
- sample_strobe:
  - One-clk pulse when tick && cnt=={1'b0,duty_active[7:1]} && state!=IDLE && duty_active!=0.
  - Never pulses when duty_active==0.
- FSM:
  - IDLE: counters held at 0, pwm_out=0, duty_active=0. If enable=1: latch prescale and go to RUN.
  - RUN: ramp toward target at boundaries. If enable=0: go to STOP on the next clk; counters continue.
  - STOP: ramp toward 0 at boundaries. If enable=1: back to RUN, no counter reset. At a boundary where the new duty_active==0: go to IDLE.
- Soft start: duty_active is 0 in the first RUN period; the first step is applied at the first boundary.
- rst mid-operation overrides everything within one clk: pwm_out=0 in the following cycle.

Decomposition:
- Package pwm_pkg: state enum (IDLE, RUN, STOP) as 2-bit logic typedef; PERIOD_MAX_DEF and MAX_STEP_DEF constants.
- One sub-module: pwm_prescaler (pre_cnt, prescale_lat, tick output; inputs load, prescale).
- FSM, slew logic and comparator remain in pwm_output_stage.

Test Plan:
- Reset: rst=1 for 3 clks with enable=1 and duty_valid=1 -> all outputs 0, busy=0; IDLE->RUN one clk after rst falls.
- Soft-start ramp:
  - Stimulus: prescale=0, duty_in=64 with duty_valid, enable=1.
  - Response: duty_active = 0, 16, 32, 48, 64 after successive 255-clk periods.
  - High time per period equals duty_active clks; period_start spacing is 255 clks.
- Limits:
  - target=255 -> pwm_out constant high once ramped.
  - target=0 -> pwm_out constant low and no sample_strobe.
  - target=10 from 0 -> a single step to 10.
- Prescale: prescale=3 -> period = 1020 clks. Change prescale to 1 mid-period -> the current period stays 1020, the next is 510.
- Boundary write and strobe position:
  - duty_valid in the same clk as a boundary -> duty_active unchanged at that boundary and updated at the next one.
  - With duty_active=100, sample_strobe occurs on the tick where cnt==50.
- Soft stop:
  - Stimulus: duty_active=40, drop enable.
  - Response: 24, 8, 0 at successive boundaries, then IDLE with busy=0.
  - Re-assert enable during STOP -> RUN resumes without a period_start glitch.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types, defaults and the duty slew helper for the PWM output stage.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

  localparam logic [7:0] PERIOD_MAX_DEF = 8'd254;
  localparam logic [7:0] MAX_STEP_DEF   = 8'd16;

  // Move cur toward tgt by at most step; 9-bit signed difference keeps the result in 0..255.
  function automatic logic [7:0] slew_step(input logic [7:0] cur,
                                           input logic [7:0] tgt,
                                           input logic [7:0] step);
    logic signed [8:0] diff;
    logic        [8:0] mag;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    mag  = $unsigned(diff[8] ? -diff : diff);
    if (mag <= {1'b0, step}) begin
      return tgt;
    end else if (diff[8]) begin
      return cur - step;
    end else begin
      return cur + step;
    end
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Tick divider: one tick every prescale_lat+1 clks while active; divisor reloads only on load_i.
module pwm_prescaler (
  input  logic       clk,
  input  logic       rst,
  input  logic       active_i,
  input  logic       load_i,
  input  logic [7:0] prescale_i,
  output logic       tick_c_o
);

  logic [7:0] pre_cnt_q;
  logic [7:0] prescale_lat_q;

  assign tick_c_o = active_i && (pre_cnt_q == prescale_lat_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q      <= 8'd0;
      prescale_lat_q <= 8'd0;
    end else begin
      if (!active_i || tick_c_o) begin
        pre_cnt_q <= 8'd0;
      end else begin
        pre_cnt_q <= pre_cnt_q + 8'd1;
      end
      if (load_i) begin
        prescale_lat_q <= prescale_i;
      end
    end
  end

endmodule

// File: rtl/pwm_output_stage.sv
// Slew-limited PWM driver with soft start/stop, period-start pulse and mid-on-time ADC strobe.
module pwm_output_stage
  import pwm_pkg::*;
#(
  parameter logic [7:0] MAX_STEP   = MAX_STEP_DEF,
  parameter logic [7:0] PERIOD_MAX = PERIOD_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] duty_in,
  input  logic       duty_valid,
  input  logic [7:0] prescale,
  input  logic       enable,
  output logic       pwm_out,
  output logic [7:0] duty_active,
  output logic       period_start,
  output logic       sample_strobe,
  output logic       busy
);

  state_e     state_q;
  logic [7:0] target_q;
  logic [7:0] duty_q;
  logic [7:0] cnt_q;
  logic       pwm_q;
  logic       period_start_q;
  logic       strobe_q;
  logic       busy_q;

  logic       tick_c;
  logic       boundary_c;
  logic       start_c;
  logic       active_c;
  logic [7:0] target_eff_c;
  logic [7:0] duty_next_c;

  assign active_c     = (state_q != IDLE);
  assign boundary_c   = tick_c && (cnt_q == PERIOD_MAX);
  assign start_c      = (state_q == IDLE) && enable;
  assign target_eff_c = (state_q == RUN) ? target_q : 8'd0;
  assign duty_next_c  = slew_step(duty_q, target_eff_c, MAX_STEP);

  pwm_prescaler u_prescaler (
    .clk        (clk),
    .rst        (rst),
    .active_i   (active_c),
    .load_i     (boundary_c || start_c),
    .prescale_i (prescale),
    .tick_c_o   (tick_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      target_q       <= 8'd0;
      duty_q         <= 8'd0;
      cnt_q          <= 8'd0;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
      strobe_q       <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      if (duty_valid) begin
        target_q <= duty_in;
      end

      pwm_q          <= active_c && (cnt_q < duty_q);
      period_start_q <= boundary_c || start_c;
      strobe_q       <= tick_c && (cnt_q == {1'b0, duty_q[7:1]}) && active_c
                        && (duty_q != 8'd0);

      if (!active_c) begin
        cnt_q <= 8'd0;
      end else if (tick_c) begin
        cnt_q <= boundary_c ? 8'd0 : cnt_q + 8'd1;
      end

      // Duty only changes at period boundaries, which never occur in IDLE.
      if (boundary_c) begin
        duty_q <= duty_next_c;
      end

      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (!enable) begin
            state_q <= STOP;
          end
        end
        STOP: begin
          if (enable) begin
            state_q <= RUN;
          end else if (boundary_c && (duty_next_c == 8'd0)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pwm_out       = pwm_q;
  assign duty_active   = duty_q;
  assign period_start  = period_start_q;
  assign sample_strobe = strobe_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_pwm_output_stage.sv
// Directed, table-driven bench for pwm_output_stage: per-period length, high time, strobe and slew.
module tb_pwm_output_stage;

  logic       clk;
  logic       rst;
  logic [7:0] duty_in;
  logic       duty_valid;
  logic [7:0] prescale;
  logic       enable;
  logic       pwm_out;
  logic [7:0] duty_active;
  logic       period_start;
  logic       sample_strobe;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  pwm_output_stage dut (
    .clk           (clk),
    .rst           (rst),
    .duty_in       (duty_in),
    .duty_valid    (duty_valid),
    .prescale      (prescale),
    .enable        (enable),
    .pwm_out       (pwm_out),
    .duty_active   (duty_active),
    .period_start  (period_start),
    .sample_strobe (sample_strobe),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit         wr;
    logic [7:0] wval;
    int         ps_at;
    logic [7:0] ps_val;
    int         exp_len;
    int         exp_high;
    int         exp_end;
    int         exp_nstr;
    int         exp_pos;
  } row_t;

  row_t rows [0:22];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs from just after a period_start sample up to and including the next one.
  task automatic measure(input bit wr, input logic [7:0] wval,
                         input int ps_at, input logic [7:0] ps_val,
                         input int en_off, input int en_on,
                         output int len, output int high, output int nstr, output int pos);
    len = 0; high = 0; nstr = 0; pos = 0;
    if (wr) begin
      duty_in    = wval;
      duty_valid = 1'b1;
    end
    for (int i = 0; i < 5000; i++) begin
      if (i == ps_at)  prescale = ps_val;
      if (i == en_off) enable   = 1'b0;
      if (i == en_on)  enable   = 1'b1;
      step();
      duty_valid = 1'b0;
      len++;
      if (pwm_out) high++;
      if (sample_strobe) begin
        nstr++;
        pos = len;
      end
      if (period_start) break;
    end
    if (!period_start) chk("period_start timeout", 0, 1);
  endtask

  int len, high, nstr, pos, n;

  initial begin
    rows[0]  = '{1'b0, 8'd0,   -1, 8'd0,  255,   0,  16, 0,  0};
    rows[1]  = '{1'b0, 8'd0,   -1, 8'd0,  255,  16,  32, 1,  9};
    rows[2]  = '{1'b0, 8'd0,   -1, 8'd0,  255,  32,  48, 1, 17};
    rows[3]  = '{1'b0, 8'd0,   -1, 8'd0,  255,  48,  64, 1, 25};
    rows[4]  = '{1'b0, 8'd0,   -1, 8'd0,  255,  64,  64, 1, 33};
    rows[5]  = '{1'b1, 8'd100, -1, 8'd0,  255,  64,  80, 1, 33};
    rows[6]  = '{1'b0, 8'd0,   -1, 8'd0,  255,  80,  96, 1, 41};
    rows[7]  = '{1'b0, 8'd0,   -1, 8'd0,  255,  96, 100, 1, 49};
    rows[8]  = '{1'b0, 8'd0,   -1, 8'd0,  255, 100, 100, 1, 51};
    rows[9]  = '{1'b1, 8'd0,   -1, 8'd0,  255, 100,  84, 1, 51};
    rows[10] = '{1'b0, 8'd0,   -1, 8'd0,  255,  84,  68, 1, 43};
    rows[11] = '{1'b0, 8'd0,   -1, 8'd0,  255,  68,  52, 1, 35};
    rows[12] = '{1'b0, 8'd0,   -1, 8'd0,  255,  52,  36, 1, 27};
    rows[13] = '{1'b0, 8'd0,   -1, 8'd0,  255,  36,  20, 1, 19};
    rows[14] = '{1'b0, 8'd0,   -1, 8'd0,  255,  20,   4, 1, 11};
    rows[15] = '{1'b0, 8'd0,   -1, 8'd0,  255,   4,   0, 1,  3};
    rows[16] = '{1'b0, 8'd0,   -1, 8'd0,  255,   0,   0, 0,  0};
    rows[17] = '{1'b1, 8'd10,  -1, 8'd0,  255,   0,  10, 0,  0};
    rows[18] = '{1'b0, 8'd0,   -1, 8'd0,  255,  10,  10, 1,  6};
    rows[19] = '{1'b0, 8'd0,    0, 8'd3,  255,  10,  10, 1,  6};
    rows[20] = '{1'b0, 8'd0,  100, 8'd1, 1020,  40,  10, 1, 24};
    rows[21] = '{1'b0, 8'd0,    0, 8'd0,  510,  20,  10, 1, 12};
    rows[22] = '{1'b0, 8'd0,   -1, 8'd0,  255,  10,  10, 1,  6};

    // Reset held with enable and duty_valid asserted
    rst = 1'b1; enable = 1'b1; duty_valid = 1'b1; duty_in = 8'd64; prescale = 8'd0;
    repeat (3) step();
    chk("reset pwm_out", int'(pwm_out), 0);
    chk("reset duty_active", int'(duty_active), 0);
    chk("reset period_start", int'(period_start), 0);
    chk("reset sample_strobe", int'(sample_strobe), 0);
    chk("reset busy", int'(busy), 0);

    rst = 1'b0;
    step();
    duty_valid = 1'b0;
    chk("start busy", int'(busy), 1);
    chk("start period_start", int'(period_start), 1);
    chk("start duty_active", int'(duty_active), 0);

    for (int r = 0; r < 23; r++) begin
      measure(rows[r].wr, rows[r].wval, rows[r].ps_at, rows[r].ps_val, -1, -1,
              len, high, nstr, pos);
      chk($sformatf("row%0d len", r), len, rows[r].exp_len);
      chk($sformatf("row%0d high", r), high, rows[r].exp_high);
      chk($sformatf("row%0d duty_end", r), int'(duty_active), rows[r].exp_end);
      chk($sformatf("row%0d strobes", r), nstr, rows[r].exp_nstr);
      chk($sformatf("row%0d strobe_pos", r), pos, rows[r].exp_pos);
    end

    // Ramp to full scale: output stays high all period
    measure(1'b1, 8'd255, -1, 8'd0, -1, -1, len, high, nstr, pos);
    n = 0;
    while (duty_active != 8'd255 && n < 20) begin
      measure(1'b0, 8'd0, -1, 8'd0, -1, -1, len, high, nstr, pos);
      n++;
    end
    chk("ramp to 255", int'(duty_active), 255);
    measure(1'b0, 8'd0, -1, 8'd0, -1, -1, len, high, nstr, pos);
    chk("full len", len, 255);
    chk("full high", high, 255);
    chk("full strobes", nstr, 1);
    chk("full strobe_pos", pos, 128);

    // Write landing on the boundary clk is deferred one period
    for (int i = 0; i < 254; i++) step();
    duty_in = 8'd200; duty_valid = 1'b1;
    step();
    duty_valid = 1'b0;
    chk("bwrite at boundary", int'(period_start), 1);
    chk("bwrite duty unchanged", int'(duty_active), 255);
    measure(1'b0, 8'd0, -1, 8'd0, -1, -1, len, high, nstr, pos);
    chk("bwrite high", high, 255);
    chk("bwrite duty next", int'(duty_active), 239);

    // Ramp down to 40
    measure(1'b1, 8'd40, -1, 8'd0, -1, -1, len, high, nstr, pos);
    n = 0;
    while (duty_active != 8'd40 && n < 20) begin
      measure(1'b0, 8'd0, -1, 8'd0, -1, -1, len, high, nstr, pos);
      n++;
    end
    chk("ramp to 40", int'(duty_active), 40);

    // Soft stop: 40 -> 24 -> 8 -> 0 then IDLE
    measure(1'b0, 8'd0, -1, 8'd0, 0, -1, len, high, nstr, pos);
    chk("stop1 len", len, 255);
    chk("stop1 high", high, 40);
    chk("stop1 duty", int'(duty_active), 24);
    chk("stop1 busy", int'(busy), 1);
    measure(1'b0, 8'd0, -1, 8'd0, -1, -1, len, high, nstr, pos);
    chk("stop2 high", high, 24);
    chk("stop2 duty", int'(duty_active), 8);
    measure(1'b0, 8'd0, -1, 8'd0, -1, -1, len, high, nstr, pos);
    chk("stop3 high", high, 8);
    chk("stop3 duty", int'(duty_active), 0);
    chk("stop3 busy", int'(busy), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("idle%0d busy", i), int'(busy), 0);
      chk($sformatf("idle%0d period_start", i), int'(period_start), 0);
      chk($sformatf("idle%0d pwm_out", i), int'(pwm_out), 0);
    end

    // Restart with soft start, then bounce enable inside one period
    enable = 1'b1;
    step();
    chk("restart busy", int'(busy), 1);
    chk("restart period_start", int'(period_start), 1);
    measure(1'b0, 8'd0, -1, 8'd0, -1, -1, len, high, nstr, pos);
    chk("restart p1 duty", int'(duty_active), 16);
    measure(1'b0, 8'd0, -1, 8'd0, -1, -1, len, high, nstr, pos);
    chk("restart p2 duty", int'(duty_active), 32);
    measure(1'b0, 8'd0, -1, 8'd0, -1, -1, len, high, nstr, pos);
    chk("restart p3 duty", int'(duty_active), 40);
    measure(1'b0, 8'd0, -1, 8'd0, 50, 120, len, high, nstr, pos);
    chk("bounce len", len, 255);
    chk("bounce high", high, 40);
    chk("bounce duty", int'(duty_active), 40);
    chk("bounce strobe_pos", pos, 21);
    chk("bounce busy", int'(busy), 1);

    // Reset mid-operation forces the pin low on the next clk
    repeat (5) step();
    chk("pre-rst pwm_out", int'(pwm_out), 1);
    rst = 1'b1;
    step();
    chk("mid-rst pwm_out", int'(pwm_out), 0);
    chk("mid-rst busy", int'(busy), 0);
    chk("mid-rst duty", int'(duty_active), 0);
    rst = 1'b0; enable = 1'b0;
    step();
    chk("post-rst busy", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
